// File: rtl/stage_id_pipe.sv
// Instruction-decode stage: register read with EX/MEM forwarding, load-use
// stall detection, control decode and a registered ID/EX output with valid/ready.
module stage_id_pipe #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_newpc,
  output logic [RA_W-1:0]   rf_addr_rs,
  output logic [RA_W-1:0]   rf_addr_rt,
  input  logic [DATA_W-1:0] rf_data_rs,
  input  logic [DATA_W-1:0] rf_data_rt,
  input  logic              ex_wr_en,
  input  logic              ex_wr_is_load,
  input  logic [RA_W-1:0]   ex_wr_addr,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              mem_wr_en,
  input  logic [RA_W-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [DATA_W-1:0] out_newpc,
  output logic [DATA_W-1:0] out_rega,
  output logic [DATA_W-1:0] out_regb,
  output logic [DATA_W-1:0] out_imm,
  output logic [RA_W-1:0]   out_dst,
  output logic              out_regwrite,
  output logic              out_memtoreg,
  output logic              out_memwrite,
  output logic              out_branch,
  output logic              out_useimm,
  output logic              out_shift,
  output logic              out_illegal,
  output logic [3:0]        out_aluop
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, imm_zext, dec_imm;
  logic [RA_W-1:0]   dec_dst;
  alu_op_e           dec_aluop;
  logic              dec_regwrite, dec_memtoreg, dec_memwrite, dec_branch;
  logic              dec_useimm, dec_shift, dec_illegal, uses_rs, uses_rt;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              ex_fwd, hazard, accept;

  assign op         = in_inst[31:26];
  assign funct      = in_inst[5:0];
  assign rs         = RA_W'(in_inst[25:21]);
  assign rt         = RA_W'(in_inst[20:16]);
  assign rd         = RA_W'(in_inst[15:11]);
  assign rf_addr_rs = rs;
  assign rf_addr_rt = rt;

  // Built bitwise so DATA_W == 16 needs no zero-width replication.
  always_comb begin
    imm_sext       = {DATA_W{in_inst[15]}};
    imm_sext[15:0] = in_inst[15:0];
    imm_zext       = '0;
    imm_zext[15:0] = in_inst[15:0];
  end

  always_comb begin
    dec_imm      = imm_sext;
    dec_dst      = '0;
    dec_aluop    = ALU_ADD;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_branch   = 1'b0;
    dec_useimm   = 1'b0;
    dec_shift    = 1'b0;
    dec_illegal  = 1'b0;
    uses_rs      = 1'b0;
    uses_rt      = 1'b0;
    case (op)
      6'b000000: begin
        dec_dst      = rd;
        dec_regwrite = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        case (funct)
          6'b100000: dec_aluop = ALU_ADD;
          6'b100010: dec_aluop = ALU_SUB;
          6'b100100: dec_aluop = ALU_AND;
          6'b100101: dec_aluop = ALU_OR;
          6'b100110: dec_aluop = ALU_XOR;
          6'b100111: dec_aluop = ALU_NOR;
          6'b101010: dec_aluop = ALU_SLT;
          6'b000000: begin dec_aluop = ALU_SLL; dec_shift = 1'b1; end
          6'b000010: begin dec_aluop = ALU_SRL; dec_shift = 1'b1; end
          6'b000011: begin dec_aluop = ALU_SRA; dec_shift = 1'b1; end
          default: begin
            // Unknown funct must not stall on operands it will never use.
            dec_illegal  = 1'b1;
            dec_dst      = '0;
            dec_regwrite = 1'b0;
            uses_rs      = 1'b0;
            uses_rt      = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001100, 6'b001101: begin
        dec_dst      = rt;
        dec_regwrite = 1'b1;
        dec_useimm   = 1'b1;
        uses_rs      = 1'b1;
        if (op == 6'b001100) begin
          dec_aluop = ALU_AND;
          dec_imm   = imm_zext;
        end else if (op == 6'b001101) begin
          dec_aluop = ALU_OR;
          dec_imm   = imm_zext;
        end
      end
      6'b100011: begin
        dec_dst      = rt;
        dec_regwrite = 1'b1;
        dec_memtoreg = 1'b1;
        dec_useimm   = 1'b1;
        uses_rs      = 1'b1;
      end
      6'b101011: begin
        dec_memwrite = 1'b1;
        dec_useimm   = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      6'b000100: begin
        dec_aluop  = ALU_SUB;
        dec_branch = 1'b1;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load still in EX has no data yet; it is caught by the hazard check instead.
  assign ex_fwd = ex_wr_en && !ex_wr_is_load;

  assign fwd_rs = (rs == '0)                          ? '0          :
                  (ex_fwd && ex_wr_addr == rs)        ? ex_wr_data  :
                  (mem_wr_en && mem_wr_addr == rs)    ? mem_wr_data : rf_data_rs;
  assign fwd_rt = (rt == '0)                          ? '0          :
                  (ex_fwd && ex_wr_addr == rt)        ? ex_wr_data  :
                  (mem_wr_en && mem_wr_addr == rt)    ? mem_wr_data : rf_data_rt;

  assign hazard   = ex_wr_en && ex_wr_is_load && (ex_wr_addr != '0) &&
                    ((uses_rs && ex_wr_addr == rs) || (uses_rt && ex_wr_addr == rt));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush beats acceptance; a bubble or flush touches only out_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_newpc    <= '0;
      out_rega     <= '0;
      out_regb     <= '0;
      out_imm      <= '0;
      out_dst      <= '0;
      out_regwrite <= 1'b0;
      out_memtoreg <= 1'b0;
      out_memwrite <= 1'b0;
      out_branch   <= 1'b0;
      out_useimm   <= 1'b0;
      out_shift    <= 1'b0;
      out_illegal  <= 1'b0;
      out_aluop    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_inst     <= in_inst;
      out_newpc    <= in_newpc;
      out_rega     <= fwd_rs;
      out_regb     <= fwd_rt;
      out_imm      <= dec_imm;
      out_dst      <= dec_dst;
      out_regwrite <= dec_regwrite;
      out_memtoreg <= dec_memtoreg;
      out_memwrite <= dec_memwrite;
      out_branch   <= dec_branch;
      out_useimm   <= dec_useimm;
      out_shift    <= dec_shift;
      out_illegal  <= dec_illegal;
      out_aluop    <= dec_aluop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
